// File: rtl/fc_layer_sequencer.sv
// Fully-connected layer sequencer: walks the weight ROM row by row against the
// input activation buffer, accumulates signed products per output neuron and
// writes one scaled, optionally rectified, saturated result per row.
//
// state | meaning
// IDLE  | waiting for start, address counters parked at 0
// MAC   | one weight*activation product issued per cycle across a row
// DRAIN | last product folds into the accumulator, row result is latched
// WRITE | y_we strobe for the finished row, accumulator cleared
// DONE  | one-cycle completion pulse back to the inference FSM
module fc_layer_sequencer #(
   parameter int IN_DIM     = 784,
   parameter int OUT_DIM    = 64,
   parameter int W_ADDR_W   = 16,
   parameter int X_ADDR_W   = 10,
   parameter int Y_ADDR_W   = 6,
   parameter int DATA_W     = 32,
   parameter int FRAC_SHIFT = 0,
   parameter int RELU_EN    = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   output logic [W_ADDR_W-1:0]        w_addr,
   input  logic signed [DATA_W-1:0]   w_data,
   output logic [X_ADDR_W-1:0]        x_addr,
   input  logic signed [DATA_W-1:0]   x_data,
   output logic                       y_we,
   output logic [Y_ADDR_W-1:0]        y_addr,
   output logic signed [DATA_W-1:0]   y_data,
   output logic                       busy,
   output logic                       done
);

   localparam int PW = 2 * DATA_W;
   localparam int AW = 2 * DATA_W + 10;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_MAC   = 3'd1;
   localparam logic [2:0] S_DRAIN = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [X_ADDR_W-1:0] COL_LOAD = X_ADDR_W'(IN_DIM - 1);
   localparam logic [Y_ADDR_W-1:0] ROW_LAST = Y_ADDR_W'(OUT_DIM - 1);

   logic [2:0]                 state_q, state_d;
   logic [W_ADDR_W-1:0]        w_addr_q;
   logic [X_ADDR_W-1:0]        x_addr_q;
   logic [X_ADDR_W-1:0]        col_left_q;
   logic [Y_ADDR_W-1:0]        row_q;
   logic                       y_we_q;
   logic [Y_ADDR_W-1:0]        y_addr_q;
   logic signed [DATA_W-1:0]   y_data_q, y_data_d;
   logic signed [PW-1:0]       prod_q, prod_d;
   logic                       prod_v_q;
   logic signed [AW-1:0]       acc_q, acc_d;
   logic signed [AW-1:0]       acc_sh, acc_rl;
   logic signed [AW-1:0]       sat_max, sat_min;

   assign w_addr = w_addr_q;
   assign x_addr = x_addr_q;
   assign y_we   = y_we_q;
   assign y_addr = y_addr_q;
   assign y_data = y_data_q;
   assign busy   = (state_q == S_MAC) || (state_q == S_DRAIN) || (state_q == S_WRITE);
   assign done   = (state_q == S_DONE);

   // Operands widened explicitly so the product is a full-precision signed value.
   assign prod_d = $signed({{DATA_W{w_data[DATA_W-1]}}, w_data})
                 * $signed({{DATA_W{x_data[DATA_W-1]}}, x_data});

   // The accumulator runs one cycle behind the product register; acc_d is the
   // value including any pending product, which is what DRAIN latches.
   assign acc_d = prod_v_q ? (acc_q + $signed({{(AW-PW){prod_q[PW-1]}}, prod_q})) : acc_q;

   assign acc_sh  = acc_d >>> FRAC_SHIFT;
   assign acc_rl  = ((RELU_EN != 0) && acc_sh[AW-1]) ? '0 : acc_sh;
   assign sat_max = $signed({{(AW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}});
   assign sat_min = $signed({{(AW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}});

   // Clamp the scaled result into the signed output range.
   always_comb begin
      y_data_d = acc_rl[DATA_W-1:0];
      if (acc_rl > sat_max) begin
         y_data_d = $signed({1'b0, {(DATA_W-1){1'b1}}});
      end else if (acc_rl < sat_min) begin
         y_data_d = $signed({1'b1, {(DATA_W-1){1'b0}}});
      end
   end

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_MAC;
         S_MAC:   if (col_left_q == '0) state_d = S_DRAIN;
         S_DRAIN: state_d = S_WRITE;
         S_WRITE: state_d = (row_q == ROW_LAST) ? S_DONE : S_MAC;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State, address counters, product/accumulator pipeline and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         w_addr_q   <= '0;
         x_addr_q   <= '0;
         col_left_q <= COL_LOAD;
         row_q      <= '0;
         y_we_q     <= 1'b0;
         y_addr_q   <= '0;
         y_data_q   <= '0;
         prod_q     <= '0;
         prod_v_q   <= 1'b0;
         acc_q      <= '0;
      end else begin
         state_q  <= state_d;
         prod_v_q <= (state_q == S_MAC);
         y_we_q   <= (state_q == S_DRAIN);
         if (state_q == S_MAC) begin
            prod_q <= prod_d;
         end
         acc_q <= (state_q == S_WRITE) ? '0 : acc_d;

         case (state_q)
            S_IDLE: begin
               w_addr_q   <= '0;
               x_addr_q   <= '0;
               row_q      <= '0;
               col_left_q <= COL_LOAD;
            end
            S_MAC: begin
               // w_addr holds on the last column so the next row resumes at +1.
               if (col_left_q == '0) begin
                  x_addr_q <= '0;
               end else begin
                  x_addr_q   <= x_addr_q + 1'b1;
                  w_addr_q   <= w_addr_q + 1'b1;
                  col_left_q <= col_left_q - 1'b1;
               end
            end
            S_DRAIN: begin
               y_addr_q <= row_q;
               y_data_q <= y_data_d;
            end
            S_WRITE: begin
               row_q      <= row_q + 1'b1;
               col_left_q <= COL_LOAD;
               if (row_q != ROW_LAST) begin
                  w_addr_q <= w_addr_q + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
